// File: rtl/bnn_sample_sequencer.sv
// -----------------------------------------------------------------------------
// bnn_sample_sequencer
//
// Front-end for a sequential BNN classifier. It accepts one packed feature
// vector per valid/ready transfer and holds it on the classifier's features
// input. It then releases the classifier from reset for a fixed settle window,
// captures the prediction, and returns the class index on a valid/ready
// result port.
//
// Ports
//   clk             single clock, all logic on the rising edge
//   rst_n           asynchronous active-low reset
//   s_valid/s_ready sample handshake (s_ready only in IDLE)
//   s_features      packed sample, FEAT_CNT fields of FEAT_BITS bits
//   bnn_features    registered sample driven to the classifier
//   bnn_rst         registered active-high classifier reset
//   bnn_prediction  classifier prediction input
//   m_valid/m_ready result handshake
//   m_class         captured class, clamped to CLASS_CNT-1
//   m_oor           the captured prediction was out of range
//   err_sticky      an out-of-range capture has happened since reset
//   done_count      number of consumed results, wraps at 16 bits
// -----------------------------------------------------------------------------
module bnn_sample_sequencer #(
  parameter int FEAT_CNT      = 19,
  parameter int FEAT_BITS     = 4,
  parameter int HIDDEN_CNT    = 40,
  parameter int CLASS_CNT     = 3,
  parameter int CW            = $clog2(CLASS_CNT),
  parameter int SETTLE_CYCLES = HIDDEN_CNT + CLASS_CNT + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_BITS*FEAT_CNT-1:0] s_features,
  output logic [FEAT_BITS*FEAT_CNT-1:0] bnn_features,
  output logic                          bnn_rst,
  input  logic [CW-1:0]                 bnn_prediction,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CW-1:0]                 m_class,
  output logic                          m_oor,
  output logic                          err_sticky,
  output logic [15:0]                   done_count
);

  localparam int FW    = FEAT_BITS * FEAT_CNT;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  // Counter value on the capture edge.
  localparam logic [CNT_W-1:0] CNT_CAPTURE  = CNT_W'(SETTLE_CYCLES);
  // Counter value on the edge that re-asserts bnn_rst. The classifier then
  // sees bnn_rst low on exactly SETTLE_CYCLES rising edges, and its
  // prediction is sampled one edge later.
  localparam logic [CNT_W-1:0] CNT_RST_RISE = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]    CLASS_MAX    = CW'(CLASS_CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             capture;
  logic             handshake;
  logic             pred_oor;
  logic [CW-1:0]    pred_class;

  // True when a raw prediction does not name a valid class.
  function automatic logic is_oor(input logic [CW-1:0] p);
    return (p > CLASS_MAX);
  endfunction

  // Saturate a raw prediction to the highest valid class index.
  function automatic logic [CW-1:0] clamp_class(input logic [CW-1:0] p);
    if (p > CLASS_MAX) begin
      return CLASS_MAX;
    end else begin
      return p;
    end
  endfunction

  assign pred_oor   = is_oor(bnn_prediction);
  assign pred_class = clamp_class(bnn_prediction);

  // Next-state logic and the per-cycle transfer/capture strobes.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        // s_ready is registered and is still low on the first cycle after
        // reset release, so acceptance must qualify on it explicitly.
        if (s_valid && s_ready) begin
          accept     = 1'b1;
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        next_state = RUN;
      end
      RUN: begin
        if (count == CNT_CAPTURE) begin
          capture    = 1'b1;
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (m_valid && m_ready) begin
          handshake  = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Settle counter: cleared in LOAD, counts every RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {CNT_W{1'b0}};
    end else begin
      case (state)
        RUN: begin
          if (capture) begin
            count <= {CNT_W{1'b0}};
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          count <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Registered s_ready: high exactly while the FSM sits in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready <= 1'b0;
    end else begin
      s_ready <= (next_state == IDLE);
    end
  end

  // Classifier reset: low from LOAD's edge until the settle window is used up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnn_rst <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          bnn_rst <= 1'b0;
        end
        RUN: begin
          bnn_rst <= (count >= CNT_RST_RISE);
        end
        default: begin
          bnn_rst <= 1'b1;
        end
      endcase
    end
  end

  // Feature hold register, written only on sample acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnn_features <= {FW{1'b0}};
    end else begin
      if (accept) begin
        bnn_features <= s_features;
      end else begin
        bnn_features <= bnn_features;
      end
    end
  end

  // Result port: class and range flag captured once, held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_class <= {CW{1'b0}};
      m_oor   <= 1'b0;
    end else begin
      if (capture) begin
        m_valid <= 1'b1;
        m_class <= pred_class;
        m_oor   <= pred_oor;
      end else if (handshake) begin
        m_valid <= 1'b0;
      end else begin
        m_valid <= m_valid;
      end
    end
  end

  // Sticky error flag: only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else begin
      if (capture && pred_oor) begin
        err_sticky <= 1'b1;
      end else begin
        err_sticky <= err_sticky;
      end
    end
  end

  // Consumed-result counter; natural 16-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count <= 16'd0;
    end else begin
      if (handshake) begin
        done_count <= done_count + 16'd1;
      end else begin
        done_count <= done_count;
      end
    end
  end

endmodule

// File: tb/tb_bnn_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bnn_sample_sequencer
//
// Drives bnn_sample_sequencer with directed and random samples. A behavioural
// classifier stand-in returns the reference class only after it has seen
// exactly SETTLE edges out of reset, and a wrong class otherwise. Expected
// results are queued at acceptance and popped by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_bnn_sample_sequencer;
  localparam int FEAT_CNT   = 19;
  localparam int FEAT_BITS  = 4;
  localparam int HIDDEN_CNT = 40;
  localparam int CLASS_CNT  = 3;
  localparam int CW         = 2;
  localparam int FW         = FEAT_CNT * FEAT_BITS;
  localparam int SETTLE     = HIDDEN_CNT + CLASS_CNT + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [FW-1:0] s_features = '0;
  logic [FW-1:0] bnn_features;
  logic          bnn_rst;
  logic [CW-1:0] bnn_prediction;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] m_class;
  logic          m_oor;
  logic          err_sticky;
  logic [15:0]   done_count;

  bnn_sample_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_features(s_features), .bnn_features(bnn_features), .bnn_rst(bnn_rst),
    .bnn_prediction(bnn_prediction), .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .m_oor(m_oor), .err_sticky(err_sticky),
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference rule: sum of feature fields mod 4 (3 is out of range), or a forced value.
  bit force_en = 1'b0;
  int force_val = 0;

  function automatic int ref_class(input logic [FW-1:0] f, input bit fe, input int fv);
    int sum;
    sum = 0;
    if (fe) return fv;
    for (int i = 0; i < FEAT_CNT; i++) sum += int'(f[i*FEAT_BITS +: FEAT_BITS]);
    return sum % 4;
  endfunction

  // Classifier stand-in: correct only after exactly SETTLE edges out of reset.
  int low_edges = 0;
  always @(posedge clk) begin
    if (bnn_rst) low_edges <= 0;
    else low_edges <= low_edges + 1;
  end

  function automatic logic [CW-1:0] classifier_out(input logic [FW-1:0] f, input int edges,
                                                   input bit fe, input int fv);
    int v;
    v = ref_class(f, fe, fv);
    if (edges != SETTLE) v = (v == 0) ? 1 : 0;
    return v[CW-1:0];
  endfunction

  assign bnn_prediction = classifier_out(bnn_features, low_edges, force_en, force_val);

  // Scoreboard.
  typedef struct {
    int          cls;
    bit          oor;
    int          acc;
  } exp_t;
  exp_t          sbq[$];
  int            cyc = 0;
  int            exp_done = 0;
  bit            exp_sticky = 1'b0;
  bit            shown = 1'b0;
  int            low_cnt = 0;
  logic [FW-1:0] last_feat = '0;
  int            last_acc = -1;
  int            acc_cyc = -1;
  bit            streaming = 1'b0;
  logic [CW-1:0] held_class = '0;
  logic          held_oor = 1'b0;
  int            sent_n = 0;

  // Stimulus-side capture: queue the expected result at each acceptance.
  always @(posedge clk) begin
    exp_t e;
    int   c;
    cyc++;
    if (!rst_n) begin
      sbq.delete();
      exp_done   = 0;
      exp_sticky = 1'b0;
      shown      = 1'b0;
      last_feat  = '0;
      last_acc   = -1;
    end else begin
      if (s_valid && s_ready) begin
        c     = ref_class(s_features, force_en, force_val);
        e.cls = (c > CLASS_CNT - 1) ? CLASS_CNT - 1 : c;
        e.oor = (c > CLASS_CNT - 1);
        e.acc = cyc;
        sbq.push_back(e);
        if (streaming && last_acc >= 0) check("accept_spacing", cyc - last_acc, SETTLE + 4);
        last_acc  = cyc;
        acc_cyc   = cyc;
        last_feat = s_features;
        low_cnt   = 0;
      end
      if (m_valid && m_ready) begin
        exp_done = (exp_done + 1) % 65536;
        shown    = 1'b0;
      end
    end
  end

  // Monitor: compare each presented result and the held outputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!bnn_rst) low_cnt++;
      check_vec("features_held", bnn_features, last_feat);
      if (m_valid && !shown) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("class", m_class, e.cls);
          check("oor", m_oor, e.oor);
          check("latency", cyc - e.acc, SETTLE + 2);
          check("rst_low_edges", low_cnt, SETTLE);
          exp_sticky = exp_sticky | e.oor;
          check("sticky", err_sticky, exp_sticky);
        end
        shown      = 1'b1;
        held_class = m_class;
        held_oor   = m_oor;
      end else if (m_valid) begin
        check("class_stable", m_class, held_class);
        check("oor_stable", m_oor, held_oor);
        check("s_ready_busy", s_ready, 0);
      end
      check("done_count", done_count, exp_done);
    end
  end

  function automatic logic [FW-1:0] rand_feat();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[FW-1:0];
  endfunction

  // Present a sample from a negedge and return at the negedge after acceptance.
  task automatic send(input logic [FW-1:0] f);
    int n;
    n = 0;
    @(negedge clk);
    s_valid    = 1'b1;
    s_features = f;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", n >= 200, 0);
    sent_n++;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || m_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n >= 400, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_bnn_rst", bnn_rst, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_class", m_class, 0);
    check("rst_m_oor", m_oor, 0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_done_count", done_count, 0);
    check_vec("rst_features", bnn_features, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", s_ready, 1);

    // Single sample, class 2, m_ready already high.
    m_ready   = 1'b1;
    force_en  = 1'b1;
    force_val = 2;
    send(rand_feat());
    drain();
    check("done_after_one", done_count, 1);

    // Out of range, then in range.
    force_val = 3;
    send(rand_feat());
    drain();
    check("oor_sticky_set", err_sticky, 1);
    force_val = 1;
    send(rand_feat());
    drain();
    check("in_range_oor", m_oor, 0);
    check("sticky_kept", err_sticky, 1);

    // Reset in the middle of RUN.
    force_val = 0;
    send(rand_feat());
    while (cyc < acc_cyc + 10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_bnn_rst", bnn_rst, 1);
    check("midrst_s_ready", s_ready, 0);
    check_vec("midrst_features", bnn_features, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sent_n = 0;
    @(negedge clk);
    check("midrst_ready_after", s_ready, 1);
    check("midrst_sticky_clear", err_sticky, 0);
    check("midrst_done_clear", done_count, 0);
    repeat (60) @(negedge clk);

    // Back-pressure with a new sample waiting.
    force_en = 1'b0;
    m_ready  = 1'b0;
    fa = rand_feat();
    fb = ~fa;
    send(fa);
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_timeout", n >= 100, 0);
    s_valid    = 1'b1;
    s_features = fb;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_s_ready", s_ready, 0);
      check("bp_m_valid", m_valid, 1);
      check_vec("bp_features", bnn_features, fa);
    end
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_after_hs", s_ready, 1);
    check("bp_valid_after_hs", m_valid, 0);
    sent_n++;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    check("bp_accepted", s_ready, 0);
    check_vec("bp_new_features", bnn_features, fb);
    drain();

    // Idle with s_valid low: nothing taken.
    repeat (10) @(negedge clk);
    check("idle_no_take", sbq.size(), 0);

    // Streaming random samples with s_valid and m_ready held high.
    streaming = 1'b1;
    last_acc  = -1;
    s_valid   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      s_features = rand_feat();
      n = 0;
      while (!s_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("stream_accept_timeout", n >= 200, 0);
      sent_n++;
      @(posedge clk);
      @(negedge clk);
    end
    s_valid   = 1'b0;
    drain();
    streaming = 1'b0;
    check("done_total", done_count, sent_n);
    check("queue_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bnn_sample_sequencer.md
# bnn_sample_sequencer

Hardware front-end that drives a sequential BNN classifier (e.g. `cardio_bnn1_bnnroperm`) in place of a bench. It accepts one packed feature vector per valid/ready transfer and holds it stable on the classifier's `features` input. It sequences the classifier's reset and settle window, then returns the captured class index on a valid/ready result port. It sits between a sample source (memory reader or streaming input) and a result sink.

## Interface
- `FEAT_CNT`, 19: features per sample.
- `FEAT_BITS`, 4: bits per feature.
- `HIDDEN_CNT`, 40: hidden neurons of the driven classifier.
- `CLASS_CNT`, 3: number of classes; `CW = $clog2(CLASS_CNT)`.
- `SETTLE_CYCLES`, `HIDDEN_CNT+CLASS_CNT+1`: rising edges the classifier sees with `bnn_rst` low before its prediction is sampled. Must be ≥1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  sample ready.
- `s_features`  in  `FEAT_BITS*FEAT_CNT`  packed sample, same packing as the classifier's `features`.
- `bnn_features`  out  `FEAT_BITS*FEAT_CNT`  registered sample to the classifier.
- `bnn_rst`  out  1  active-high reset to the classifier.
- `bnn_prediction`  in  `CW`  classifier's `prediction` output.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result ready.
- `m_class`  out  `CW`  registered class index, clamped to `CLASS_CNT-1`.
- `m_oor`  out  1  this result was out of range (clamped).
- `err_sticky`  out  1  set on any out-of-range capture; cleared only by `rst_n`.
- `done_count`  out  16  number of results consumed; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `s_ready`=1.
  - On `s_valid&&s_ready`: latch `s_features` into `bnn_features` and go to LOAD.
- LOAD: lasts one cycle, then go to RUN with cycle counter = 0.
- RUN:
  - Counter increments every cycle.
  - On the edge where counter == `SETTLE_CYCLES`:
    - capture `bnn_prediction`;
    - if the captured value > `CLASS_CNT-1`, set `m_class`=`CLASS_CNT-1`, `m_oor`=1 and `err_sticky`=1; otherwise pass it through with `m_oor`=0;
    - set `m_valid`=1 and go to DONE.
- DONE:
  - `m_valid`=1; `m_class` and `m_oor` held stable until `m_valid&&m_ready`.
  - On that handshake: `m_valid`→0, `done_count`+1, go to IDLE.
- `bnn_rst` is registered. It is 1 in IDLE, LOAD and DONE and 0 only in RUN, so the classifier is held in reset whenever it is not computing.
- `s_ready`=1 only in IDLE. No acceptance while busy; upstream back-pressure is the only flow control.
- `bnn_features` changes only on acceptance. It is stable from LOAD through DONE.
- Counter width is `$clog2(SETTLE_CYCLES+1)`.

## Timing
- Reset values (async on `rst_n` low, any state, including mid-RUN or DONE):
  - `s_ready`=0 while `rst_n` low; 1 after release (IDLE).
  - `bnn_rst`=1; `bnn_features`=0.
  - `m_valid`=0, `m_class`=0, `m_oor`=0, `err_sticky`=0, `done_count`=0.
  - Any in-flight sample is discarded; no result is emitted for it.
- Latency:
  - Acceptance edge E0. `bnn_rst` falls after E1.
  - The classifier sees `bnn_rst` low on edges E2…E(SETTLE_CYCLES+1).
  - Capture at E(SETTLE_CYCLES+2); `m_valid` high after it. Default: 46 edges.
- Throughput: with `m_ready` held 1 and `s_valid` held 1, the next acceptance is at E0+`SETTLE_CYCLES`+4 (48 edges at defaults).
- `m_valid` must not drop without a handshake. `m_ready` asserted before `m_valid` is legal and completes the handshake on the first DONE cycle.
- `s_valid` deasserting before acceptance is legal; no sample is taken.
- `done_count` at 0xFFFF plus one handshake → 0x0000.

## Test plan
- Reset mid-RUN:
  - Stimulus: accept a sample, pull `rst_n` low at E10 for 2 cycles.
  - Required: `m_valid` 0 immediately, `bnn_rst` 1, `bnn_features`=0, `s_ready` high one cycle after release, no result emitted.
- Single sample, defaults, classifier model returning 2:
  - `bnn_rst` low for exactly 44 edges.
  - `m_valid` rises 46 edges after acceptance with `m_class`=2, `m_oor`=0.
  - `done_count`=1 after the handshake.
- Back-pressure:
  - Stimulus: hold `m_ready`=0 for 20 cycles in DONE while `s_valid`=1 with a new sample.
  - Required: `s_ready` stays 0, `m_class` stable, `bnn_features` unchanged; the new sample is accepted 2 edges after the `m_ready` handshake.
- Out of range:
  - Stimulus: model drives `bnn_prediction`=3 with `CLASS_CNT`=3.
  - Required: `m_class`=2, `m_oor`=1, `err_sticky`=1.
  - A following in-range result gives `m_oor`=0 with `err_sticky` still 1.
- Streaming:
  - Stimulus: 1000 samples from `cardio.memh`, `s_valid` and `m_ready` tied high.
  - Required: results in order, identical to the bench reference classes; 48-edge spacing; `done_count`=1000.
- Wrap:
  - Stimulus: preload or run 65536 handshakes.
  - Required: `done_count` returns to 0.
